// File: rtl/sync_fifo_system.sv
// Synchronous FIFO with registered occupancy flags, sticky under/overflow
// indicators and a selectable registered or first-word-fall-through read port.
module sync_fifo_system #(
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  write_req_i,
    input  logic                  read_req_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  clear_flags_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_empty_o,
    output logic                  almost_full_o,
    output logic [PTR_WIDTH:0]    count_o,
    output logic                  uf_o,
    output logic                  of_o
);

    localparam int DEPTH = 1 << PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] AE_THR   = (PTR_WIDTH+1)'(AE_LEVEL);
    localparam logic [PTR_WIDTH:0] AF_THR   = (PTR_WIDTH+1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0] WRAP_BIT = {1'b1, {PTR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_WIDTH:0] wptr_reg, rptr_reg;
    logic [PTR_WIDTH:0] wptr_next, rptr_next, count_next;
    logic               empty_reg, full_reg, ae_reg, af_reg, uf_reg, of_reg;
    logic [PTR_WIDTH:0] count_reg;
    logic               wr_acc, rd_acc;

    // Acceptance uses the registered flags, so a full FIFO rejects a write
    // even when a read frees a slot on the same edge (and vice versa).
    assign wr_acc = write_req_i & ~full_reg;
    assign rd_acc = read_req_i  & ~empty_reg;

    assign wptr_next  = wptr_reg + {{PTR_WIDTH{1'b0}}, wr_acc};
    assign rptr_next  = rptr_reg + {{PTR_WIDTH{1'b0}}, rd_acc};
    assign count_next = wptr_next - rptr_next;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
            ae_reg    <= 1'b1;
            af_reg    <= 1'b0;
            uf_reg    <= 1'b0;
            of_reg    <= 1'b0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
            empty_reg <= (wptr_next == rptr_next);
            full_reg  <= ((wptr_next ^ rptr_next) == WRAP_BIT);
            ae_reg    <= (count_next <= AE_THR);
            af_reg    <= (count_next >= AF_THR);
            // A new error on the clearing edge keeps the flag set.
            uf_reg    <= (read_req_i  & empty_reg) | (uf_reg & ~clear_flags_i);
            of_reg    <= (write_req_i & full_reg)  | (of_reg & ~clear_flags_i);
        end
    end

    // Storage is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wptr_reg[PTR_WIDTH-1:0]] <= data_in_i;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign data_out_o = mem[rptr_reg[PTR_WIDTH-1:0]];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] dout_reg;

            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) begin
                    dout_reg <= '0;
                end else if (rd_acc) begin
                    dout_reg <= mem[rptr_reg[PTR_WIDTH-1:0]];
                end
            end

            assign data_out_o = dout_reg;
        end
    endgenerate

    assign empty_o        = empty_reg;
    assign full_o         = full_reg;
    assign almost_empty_o = ae_reg;
    assign almost_full_o  = af_reg;
    assign count_o        = count_reg;
    assign uf_o           = uf_reg;
    assign of_o           = of_reg;

endmodule
